mac_row_feeder: RTL
===================

// Module: mac_row_feeder
// PURPOSE
//  Upstream feeder for a row of MAC array inputs (Ain side).
//  - Buffers a ROWS x DEPTH operand matrix, loaded one byte per cycle over a valid/ready port.
//  - On start, pulses a clear to the array, then streams each row with a diagonal skew:
//    row r starts r cycles after row 0, with per-row enables. This matches the 1-cycle
//    En/B forwarding of the systolic MAC chain.
//  - The B-side feeder is a second instance of this block.
// PARAMETERS
//  ROWS    8  number of MAC rows fed (one lane per row)
//  DEPTH   8  vector length K; bytes streamed per row per run
//  DATA_W  8  operand width, bits
// PORTS
//  clk       in   1            system clock, rising edge
//  rst       in   1            asynchronous, active-high reset
//  wr_valid  in   1            load byte valid
//  wr_ready  out  1            buffer can accept a byte (IDLE/FILL only)
//  wr_data   in   DATA_W       load byte; row-major order: row 0 k=0..DEPTH-1, row 1, ...
//  start     in   1            begin streaming; honoured only in LOADED
//  busy      out  1            high in CLEAR and RUN
//  done      out  1            1-cycle pulse when a run completes
//  clr_out   out  1            1-cycle clear to every MAC Clr
//  en_out    out  ROWS         per-row MAC En
//  a_out     out  ROWS*DATA_W  per-row operand; lane r = a_out[r*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - State = IDLE; all counters = 0.
//    - busy, done, clr_out, en_out, a_out = 0; wr_ready = 0 while rst is high.
//    - Buffer RAM is not cleared, but it is treated as empty.
//  - FSM states: IDLE, FILL, LOADED, CLEAR, RUN, DONE.
//    - IDLE/FILL: wr_ready = 1.
//    - A byte is accepted when wr_valid & wr_ready. It is written to address wr_cnt, then wr_cnt++.
//    - The first accept moves IDLE -> FILL.
//    - The accept with wr_cnt == ROWS*DEPTH-1 moves to LOADED; wr_ready = 0 on the next cycle.
//    - LOADED: wr_ready = 0. start = 1 -> CLEAR.
//    - start in any other state is ignored, with no side effects.
//    - CLEAR: exactly one cycle with clr_out = 1, busy = 1; t = 0; next state RUN.
//    - RUN: t counts 0 .. DEPTH+ROWS-2, so the state lasts DEPTH+ROWS-1 cycles.
//      - Lane r: en_out[r] = 1 iff r <= t < r+DEPTH; a_out lane r = A[r][t-r] while enabled, else 0.
//      - When t == DEPTH+ROWS-2 -> DONE.
//    - DONE: one cycle with done = 1, busy = 0, en_out = 0; then IDLE. wr_cnt = 0, buffer empty.
//  - Output timing: all outputs are registered. In each RUN cycle, en_out and a_out for that t
//    are valid on the same clock edge.
//  - Latency:
//    - start sampled at edge N -> clr_out high N+1 -> row 0 first byte N+2.
//    - Row ROWS-1 last byte at N+1+DEPTH+ROWS-1.
//    - done at the following cycle.
//  - Write port:
//    - wr_valid while wr_ready = 0 is dropped, not queued.
//    - wr_data is ignored when not accepted.
//  - Widths: wr_cnt is clog2(ROWS*DEPTH) bits, t is clog2(DEPTH+ROWS) bits. No arithmetic on data.
//  - Reset mid-run: outputs go to 0 immediately (async); the run is abandoned and no done is issued.
//    After release the block is in IDLE.
//  - Simultaneous start and wr_valid in LOADED: start is taken; the write is not accepted.
// TESTING  (ROWS=8, DEPTH=8, DATA_W=8)
//  1 Reset: assert rst mid-cycle -> all outputs 0 asynchronously; after release wr_ready = 1,
//    busy = 0.
//  2 Full load + run:
//    - Stimulus: load byte r*16+k for 64 beats, then pulse start.
//    - wr_ready drops after the 64th accept.
//    - clr_out high 1 cycle; then 15 RUN cycles.
//    - Row 0: en t=0..7, data 0x00..0x07. Row 7: en t=7..14, data 0x70..0x77.
//    - done pulses at t=15.
//  3 Backpressure/gaps: random wr_valid gaps over 64 bytes; start pulsed during FILL
//    -> ignored; run data matches test 2.
//  4 Illegal inputs:
//    - start and wr_valid during RUN -> no restart; no accept (wr_ready = 0).
//    - en_out pattern unchanged.
//  5 Reset mid-run: assert rst at t=4 -> en_out/a_out = 0 at once; no done.
//    Reload 64 bytes and run -> correct output.
//  6 Back-to-back: after done, reload with 0xFF-(r*16+k) and start
//    -> second run is correct; no stale data from the first load.

Source files
------------

// File: rtl/mac_row_feeder.sv
// Row-operand feeder for a systolic MAC array: buffers a ROWS x DEPTH byte matrix,
// then streams each row with a one-cycle-per-row diagonal skew after a single clear pulse.
module mac_row_feeder #(
  parameter int ROWS   = 8,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     clr_out,
  output logic [ROWS-1:0]          en_out,
  output logic [ROWS*DATA_W-1:0]   a_out
);

  localparam int NBYTES = ROWS * DEPTH;
  localparam int AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW     = $clog2(DEPTH + ROWS);
  localparam int LAST_T = DEPTH + ROWS - 2;

  typedef enum logic [2:0] {IDLE, FILL, LOADED, CLEAR, RUN, DONE} state_t;

  state_t                  state, state_nx;
  logic [AW-1:0]           wr_cnt;
  logic [TW-1:0]           t, t_nx;
  logic [DATA_W-1:0]       mem [NBYTES];
  logic                    accept;
  logic [ROWS-1:0]         en_nx;
  logic [ROWS*DATA_W-1:0]  a_nx;

  assign accept = wr_valid & wr_ready;

  always_comb begin
    state_nx = state;
    t_nx     = t;
    case (state)
      IDLE, FILL: begin
        if (accept) state_nx = (wr_cnt == AW'(NBYTES - 1)) ? LOADED : FILL;
      end
      LOADED: begin
        if (start) state_nx = CLEAR;
      end
      CLEAR: begin
        state_nx = RUN;
        t_nx     = '0;
      end
      RUN: begin
        if (t == TW'(LAST_T)) begin
          state_nx = DONE;
          t_nx     = '0;
        end else begin
          t_nx = t + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane outputs are computed from the next step so they register together with state/t.
  always_comb begin
    en_nx = '0;
    a_nx  = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (state_nx == RUN && 32'(t_nx) >= r && 32'(t_nx) < r + DEPTH) begin
        en_nx[r]                 = 1'b1;
        a_nx[r*DATA_W +: DATA_W] = mem[AW'(r * DEPTH + 32'(t_nx) - r)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      t        <= '0;
      wr_cnt   <= '0;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      clr_out  <= 1'b0;
      en_out   <= '0;
      a_out    <= '0;
    end else begin
      state    <= state_nx;
      t        <= t_nx;
      if (accept)
        wr_cnt <= wr_cnt + 1'b1;
      else if (state == DONE)
        wr_cnt <= '0;
      wr_ready <= (state_nx == IDLE) || (state_nx == FILL);
      busy     <= (state_nx == CLEAR) || (state_nx == RUN);
      done     <= (state_nx == DONE);
      clr_out  <= (state_nx == CLEAR);
      en_out   <= en_nx;
      a_out    <= a_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt] <= wr_data;
  end

endmodule
